// File: rtl/midi_note_ctrl.sv
// Monophonic MIDI channel-voice decoder driving an oscillator's note/enable/phase-reset controls.
// Running status is honoured; realtime bytes pass through without disturbing a partial message.
module midi_note_ctrl #(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] note_o,
    output logic [6:0] velocity_o,
    output logic       enable_o,
    output logic       nrstPhase_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_D1   = 2'd1,
        ST_D2   = 2'd2
    } state_e;

    // Handshake: a byte is consumed on the rising clk_i edge where valid_i && ready_o.
    state_e     state_q, state_d;
    logic [7:0] status_q, status_d;
    logic [6:0] key_q, key_d;
    logic [6:0] note_q, note_d;
    logic [6:0] vel_q, vel_d;
    logic       enable_q, enable_d;
    logic       nrst_phase_q, nrst_phase_d;
    logic       ready_q;

    logic       accept;
    logic [3:0] msg_type;
    logic       own_channel;

    assign accept      = valid_i && ready_q;
    assign msg_type    = status_q[7:4];
    assign own_channel = (status_q[3:0] == CHANNEL);

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        key_d        = key_q;
        note_d       = note_q;
        vel_d        = vel_q;
        enable_d     = enable_q;
        nrst_phase_d = 1'b1;

        if (accept) begin
            if (data_i[7]) begin
                if (data_i < 8'hF0) begin
                    status_d = data_i;
                    state_d  = ST_D1;
                end else if (data_i < 8'hF8) begin
                    status_d = 8'h00;
                    state_d  = ST_IDLE;
                end
                // 0xF8-0xFF realtime: deliberately no effect
            end else begin
                case (state_q)
                    ST_D1: begin
                        if (msg_type == 4'hC || msg_type == 4'hD) begin
                            state_d = ST_D1;
                        end else begin
                            key_d   = data_i[6:0];
                            state_d = ST_D2;
                        end
                    end
                    ST_D2: begin
                        state_d = ST_D1;
                        if (own_channel) begin
                            if (msg_type == 4'h9 && data_i[6:0] != 7'd0) begin
                                note_d       = key_q;
                                vel_d        = data_i[6:0];
                                enable_d     = 1'b1;
                                nrst_phase_d = 1'b0;
                            end else if (msg_type == 4'h8 || msg_type == 4'h9) begin
                                if (enable_q && key_q == note_q) begin
                                    enable_d = 1'b0;
                                end
                            end else if (msg_type == 4'hB && key_q == 7'd123) begin
                                enable_d = 1'b0;
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q      <= ST_IDLE;
            status_q     <= 8'h00;
            key_q        <= 7'd0;
            note_q       <= 7'd0;
            vel_q        <= 7'd0;
            enable_q     <= 1'b0;
            nrst_phase_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            key_q        <= key_d;
            note_q       <= note_d;
            vel_q        <= vel_d;
            enable_q     <= enable_d;
            nrst_phase_q <= nrst_phase_d;
            ready_q      <= 1'b1;
        end
    end

    assign ready_o     = ready_q;
    assign note_o      = {1'b0, note_q};
    assign velocity_o  = vel_q;
    assign enable_o    = enable_q;
    assign nrstPhase_o = nrst_phase_q;

endmodule

// File: tb/tb_midi_note_ctrl.sv
// Directed self-checking bench for midi_note_ctrl (CHANNEL=0): note on/off, running status,
// channel filtering, realtime/system interleaving, all-notes-off and mid-message reset.
module tb_midi_note_ctrl;

    logic       clk_i;
    logic       nrst_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] note_o;
    logic [6:0] velocity_o;
    logic       enable_o;
    logic       nrstPhase_o;

    int n_vec;
    int n_err;
    int pulse_cnt;

    midi_note_ctrl #(.CHANNEL(4'd0)) dut (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .note_o      (note_o),
        .velocity_o  (velocity_o),
        .enable_o    (enable_o),
        .nrstPhase_o (nrstPhase_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Phase-reset pulses counted as seen at each rising edge, outside reset.
    always @(posedge clk_i) begin
        if (nrst_i && !nrstPhase_o) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [7:0] b);
        int waited;
        waited  = 0;
        data_i  = b;
        valid_i = 1'b1;
        while (!ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        if (!ready_o) check("ready_timeout", {15'd0, ready_o}, 16'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] note, input logic [6:0] vel,
                              input logic en, input logic nph);
        check({tag, "_note"}, {8'd0, note_o}, {8'd0, note});
        check({tag, "_vel"}, {9'd0, velocity_o}, {9'd0, vel});
        check({tag, "_en"}, {15'd0, enable_o}, {15'd0, en});
        check({tag, "_nph"}, {15'd0, nrstPhase_o}, {15'd0, nph});
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        pulse_cnt = 0;
        nrst_i    = 1'b0;
        valid_i   = 1'b0;
        data_i    = 8'h00;

        // Test 1: reset values, then a single Note On
        repeat (3) @(negedge clk_i);
        check("rst_ready", {15'd0, ready_o}, 16'd0);
        check_outs("rst", 8'h00, 7'h00, 1'b0, 1'b1);
        nrst_i = 1'b1;
        tick();
        check("ready_after_rst", {15'd0, ready_o}, 16'd1);
        send(8'h90); send(8'h3C); send(8'h64);
        check_outs("non1", 8'h3C, 7'h64, 1'b1, 1'b0);
        tick();
        check("non1_nph_back", {15'd0, nrstPhase_o}, 16'd1);

        // Test 2: running status Note On
        send(8'h40); send(8'h50);
        check_outs("run_non", 8'h40, 7'h50, 1'b1, 1'b0);
        tick();
        check("pulses_t2", pulse_cnt[15:0], 16'd2);

        // Test 3: non-matching then matching Note Off
        send(8'h80); send(8'h3C); send(8'h00);
        check_outs("noff_miss", 8'h40, 7'h50, 1'b1, 1'b1);
        send(8'h90); send(8'h40); send(8'h00);
        check_outs("noff_hit", 8'h40, 7'h50, 1'b0, 1'b1);

        // Test 4: foreign channel, program change alignment, then Note On
        send(8'h91); send(8'h3C); send(8'h64);
        check_outs("other_ch", 8'h40, 7'h50, 1'b0, 1'b1);
        send(8'hC0); send(8'h05); send(8'h07);
        check_outs("prog_chg", 8'h40, 7'h50, 1'b0, 1'b1);
        send(8'h90); send(8'h30); send(8'h10);
        check_outs("after_pc", 8'h30, 7'h10, 1'b1, 1'b0);
        tick();
        check("pulses_t4", pulse_cnt[15:0], 16'd3);

        // Test 5: realtime is transparent, system common aborts
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        check_outs("rt_mid", 8'h3C, 7'h64, 1'b1, 1'b0);
        send(8'h90); send(8'h45); send(8'hF0); send(8'h64);
        check_outs("sys_abort", 8'h3C, 7'h64, 1'b1, 1'b1);
        send(8'h46); send(8'h7F);
        check_outs("idle_drop", 8'h3C, 7'h64, 1'b1, 1'b1);
        check("pulses_t5", pulse_cnt[15:0], 16'd4);

        // Test 6: other controller, All Notes Off, then reset mid-message
        send(8'hB0); send(8'h07); send(8'h00);
        check("cc7_en", {15'd0, enable_o}, 16'd1);
        send(8'hB0); send(8'h7B); send(8'h00);
        check_outs("all_off", 8'h3C, 7'h64, 1'b0, 1'b1);
        send(8'h90);
        nrst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("midrst_ready", {15'd0, ready_o}, 16'd0);
        nrst_i = 1'b1;
        tick();
        send(8'h3C); send(8'h64);
        check_outs("post_rst", 8'h00, 7'h00, 1'b0, 1'b1);
        tick();
        check("pulses_final", pulse_cnt[15:0], 16'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
